// File: rtl/csa_iter_add_ctrl.sv
// Iterative DW-bit add/subtract built around one shared 4-bit carry-select slice.
// One nibble per cycle, LSB first, with valid/ready on request and result sides.
//
// state | meaning
// IDLE  | ready for a request; operands latched on I_VALID
// RUN   | one nibble per edge through the shared slice
// DONE  | result held on O_SUM/O_CO/O_V until I_READY
module csa_iter_add_ctrl #(
    parameter int DW = 32
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic          I_VALID,
    output logic          O_READY,
    input  logic [DW-1:0] I_A,
    input  logic [DW-1:0] I_B,
    input  logic          I_SUB,
    output logic          O_VALID,
    input  logic          I_READY,
    output logic [DW-1:0] O_SUM,
    output logic          O_CO,
    output logic          O_V
);

    localparam int NS = DW / 4;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   bx_q;
    logic            carry_q;
    logic [IW-1:0]   idx;

    logic [IW+1:0]   nib_pos;
    logic [DW-1:0]   a_sh;
    logic [DW-1:0]   b_sh;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [4:0]      sum_c0;
    logic [4:0]      sum_c1;
    logic [4:0]      slice;
    logic            slice_co;
    logic            slice_v;
    logic [DW-1:0]   sum_mask;
    logic [DW-1:0]   sum_ins;

    assign nib_pos = {idx, 2'b00};
    assign a_sh    = a_q >> nib_pos;
    assign b_sh    = bx_q >> nib_pos;
    assign a_nib   = a_sh[3:0];
    assign b_nib   = b_sh[3:0];

    // Carry-select slice: both carry-in results precomputed, carry reg picks one.
    always_comb begin
        sum_c0   = {1'b0, a_nib} + {1'b0, b_nib};
        sum_c1   = sum_c0 + 5'd1;
        slice    = carry_q ? sum_c1 : sum_c0;
        slice_co = slice[4];
        // Carry into the slice MSB recovered from its sum bit and operand bits.
        slice_v  = (slice[3] ^ a_nib[3] ^ b_nib[3]) ^ slice_co;
    end

    assign sum_mask = ~(DW'(4'hF) << nib_pos);
    assign sum_ins  = DW'(slice[3:0]) << nib_pos;

    assign O_READY = ~I_RST & (state == IDLE);

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state   <= IDLE;
            a_q     <= '0;
            bx_q    <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            O_VALID <= 1'b0;
            O_SUM   <= '0;
            O_CO    <= 1'b0;
            O_V     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_VALID) begin
                        a_q     <= I_A;
                        bx_q    <= I_B ^ {DW{I_SUB}};
                        carry_q <= I_SUB;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    O_SUM   <= (O_SUM & sum_mask) | sum_ins;
                    carry_q <= slice_co;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        O_CO    <= slice_co;
                        O_V     <= slice_v;
                        O_VALID <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (I_READY) begin
                        O_VALID <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_iter_add_ctrl.sv
// Bench for csa_iter_add_ctrl (DW=32): directed corner cases plus random
// operations against a signed/unsigned integer-arithmetic reference.
module tb_csa_iter_add_ctrl;

    localparam int DW = 32;
    localparam int NS = DW / 4;

    logic          clk;
    logic          I_RST;
    logic          I_VALID;
    logic          O_READY;
    logic [DW-1:0] I_A;
    logic [DW-1:0] I_B;
    logic          I_SUB;
    logic          O_VALID;
    logic          I_READY;
    logic [DW-1:0] O_SUM;
    logic          O_CO;
    logic          O_V;

    int checks = 0;
    int errors = 0;

    csa_iter_add_ctrl #(.DW(DW)) dut (
        .I_CLK  (clk),
        .I_RST  (I_RST),
        .I_VALID(I_VALID),
        .O_READY(O_READY),
        .I_A    (I_A),
        .I_B    (I_B),
        .I_SUB  (I_SUB),
        .O_VALID(O_VALID),
        .I_READY(I_READY),
        .O_SUM  (O_SUM),
        .O_CO   (O_CO),
        .O_V    (O_V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views.
    task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] sum, output logic co, output logic v);
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            co = (ur >= 64'sd4294967296);
        end
        sum = ur[31:0];
        v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input int hold, input bit poke);
        logic [31:0] es;
        logic        eco;
        logic        ev;
        ref_op(a, b, sub, es, eco, ev);
        @(negedge clk);
        chk("ready_idle", 64'(O_READY), 64'd1);
        I_VALID = 1'b1;
        I_A     = a;
        I_B     = b;
        I_SUB   = sub;
        I_READY = (hold == 0);
        @(negedge clk);
        I_VALID = poke;
        I_A     = $urandom;
        I_B     = $urandom;
        I_SUB   = 1'($urandom_range(0, 1));
        chk("ready_run", 64'(O_READY), 64'd0);
        for (int c = 1; c <= NS; c++) begin
            @(negedge clk);
            chk("valid_latency", 64'(O_VALID), 64'(c == NS));
        end
        chk("sum", 64'(O_SUM), 64'(es));
        chk("co", 64'(O_CO), 64'(eco));
        chk("v", 64'(O_V), 64'(ev));
        for (int h = 0; h < hold; h++) begin
            I_A = $urandom;
            I_B = $urandom;
            @(negedge clk);
            chk("hold_valid", 64'(O_VALID), 64'd1);
            chk("hold_sum", {31'd0, O_CO, O_V, O_SUM}, {31'd0, eco, ev, es});
            chk("hold_ready", 64'(O_READY), 64'd0);
        end
        I_READY = 1'b1;
        @(negedge clk);
        chk("valid_clear", 64'(O_VALID), 64'd0);
        chk("ready_back", 64'(O_READY), 64'd1);
        I_VALID = 1'b0;
        I_READY = 1'b0;
    endtask

    initial begin
        I_RST   = 1'b1;
        I_VALID = 1'b0;
        I_A     = '0;
        I_B     = '0;
        I_SUB   = 1'b0;
        I_READY = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", 64'(O_READY), 64'd0);
        I_RST = 1'b0;
        #1;
        chk("ready_after_rst", 64'(O_READY), 64'd1);
        @(negedge clk);
        chk("rst_outputs", {31'd0, O_VALID, O_CO, O_V, O_SUM}, 64'd0);
        chk("rst_ready", 64'(O_READY), 64'd1);

        run_op(32'h0000000F, 32'h00000001, 1'b0, 0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 1'b0);
        run_op(32'd5, 32'd7, 1'b1, 0, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 2, 1'b0);
        run_op(32'h12345678, 32'h0FEDCBA9, 1'b0, 5, 1'b1);
        run_op(32'h00000000, 32'h00000000, 1'b1, 0, 1'b1);

        for (int n = 0; n < 24; n++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        // Abort mid-RUN: reset lands on the third RUN edge.
        @(negedge clk);
        I_VALID = 1'b1;
        I_A     = 32'd3;
        I_B     = 32'd4;
        I_SUB   = 1'b0;
        I_READY = 1'b1;
        @(negedge clk);
        I_VALID = 1'b0;
        repeat (2) @(negedge clk);
        I_RST = 1'b1;
        @(negedge clk);
        chk("abort_valid", 64'(O_VALID), 64'd0);
        chk("abort_ready_rst", 64'(O_READY), 64'd0);
        chk("abort_sum", 64'(O_SUM), 64'd0);
        I_RST = 1'b0;
        #1;
        chk("abort_idle", 64'(O_READY), 64'd1);
        for (int c = 0; c < NS + 2; c++) begin
            @(negedge clk);
            chk("abort_no_valid", 64'(O_VALID), 64'd0);
        end
        I_READY = 1'b0;
        run_op(32'd1, 32'd1, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
